cart_load_ctrl: RTL and testbench

Sequences cartridge loading for the 2600 core and owns the shared cartridge ROM ports. It routes HPS ioctl download bytes into the ROM write port and holds the CPU core in reset during the load. After the load it optionally scans the ROM read port for the SuperChip RAM signature. It then decides force_bs, sc and rom_size and releases the core after a fixed hold time. While running, it grants the ROM read port to the CPU.

---
 rtl/cart_load_ctrl_if.sv | 38 +++
 rtl/cart_load_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_cart_load_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_load_ctrl_if.sv
// Bundles the HPS download, ROM port and core-control signals of cart_load_ctrl.
// The controller connects through the slave modport; the HPS/ROM/core side uses master.
interface cart_load_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [31:0]       ioctl_file_ext;
  logic [1:0]        sc_mode;
  logic              user_reset;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [7:0]        rom_wdata;
  logic [ADDR_W-1:0] rom_raddr;
  logic [7:0]        rom_rdata;
  logic [ADDR_W-1:0] cpu_raddr;
  logic              core_reset;
  logic [3:0]        force_bs;
  logic              sc;
  logic [16:0]       rom_size;
  logic              busy;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_file_ext,
           sc_mode, user_reset, rom_rdata, cpu_raddr,
    input  rom_we, rom_waddr, rom_wdata, rom_raddr, core_reset, force_bs, sc,
           rom_size, busy
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_file_ext,
           sc_mode, user_reset, rom_rdata, cpu_raddr,
    output rom_we, rom_waddr, rom_wdata, rom_raddr, core_reset, force_bs, sc,
           rom_size, busy
  );
endinterface

// File: rtl/cart_load_ctrl.sv
// Cartridge load sequencer for the 2600 core: ROM download, optional SuperChip scan,
// mapper/sc decision and core reset hold. Define ROM_SCAN_EN to build the signature scan.
module cart_load_ctrl #(
  parameter int ADDR_W      = 15,
  parameter int RESET_HOLD  = 255,
  parameter int SC_FILL_LEN = 256
) (
  input logic             clk_sys,
  input logic             reset_n,
  cart_load_ctrl_if.slave bus
);
  localparam int HOLD_W = $clog2(RESET_HOLD + 2);

  typedef enum logic [2:0] {RUN, LOAD, SCAN, FINISH, HOLD} state_t;
  state_t state, state_nxt;

  logic              dl_q, dl_rise, dl_fall;
  logic [HOLD_W-1:0] hold_cnt;
  logic [16:0]       size_acc;
  logic [3:0]        bs_dec, ext_bs, bs_fin;
  logic              s_tag, sc_auto, sc_fin;
  logic              wr_ok;
  logic [25:0]       addr_p1;
  logic [16:0]       wr_size;
  logic [23:0]       ext;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [7:0]        rom_wdata;
  logic [3:0]        force_bs;
  logic              sc;
  logic [16:0]       rom_size;

  assign dl_rise = bus.ioctl_download & ~dl_q;
  assign dl_fall = ~bus.ioctl_download & dl_q;
  // The rise cycle is already part of the load even though state still shows the old value.
  assign wr_ok   = bus.ioctl_download & bus.ioctl_wr & (state == LOAD || dl_rise);
  assign addr_p1 = {1'b0, bus.ioctl_addr} + 26'd1;
  assign wr_size = (addr_p1 > 26'h1FFFF) ? 17'h1FFFF : addr_p1[16:0];

  always_comb begin
    ext = (bus.ioctl_file_ext[23:16] == ".") ? bus.ioctl_file_ext[23:0]
                                             : bus.ioctl_file_ext[31:8];
    case (ext)
      ".F8":   ext_bs = 4'd1;
      ".F6":   ext_bs = 4'd2;
      ".FE":   ext_bs = 4'd3;
      ".E0":   ext_bs = 4'd4;
      ".3F":   ext_bs = 4'd5;
      ".F4":   ext_bs = 4'd6;
      ".P2":   ext_bs = 4'd7;
      ".FA":   ext_bs = 4'd8;
      ".CV":   ext_bs = 4'd9;
      default: ext_bs = 4'd0;
    endcase
  end

  always_comb begin
    bs_fin = bs_dec;
    if (bs_dec == 4'd0) begin
      if (size_acc <= 17'd4096)       bs_fin = 4'd0;
      else if (size_acc <= 17'd8192)  bs_fin = 4'd1;
      else if (size_acc <= 17'd16384) bs_fin = 4'd2;
      else if (size_acc <= 17'd32768) bs_fin = 4'd6;
      else                            bs_fin = 4'd0;
    end
    if (bus.sc_mode == 2'd1)  sc_fin = 1'b0;
    else if (bus.sc_mode[1])  sc_fin = 1'b1;
    else                      sc_fin = s_tag | sc_auto;
  end

`ifdef ROM_SCAN_EN
  localparam int OFF_W = $clog2(SC_FILL_LEN);

  logic [2:0]        bnk, bank_last, bank_last_nxt;
  logic [OFF_W-1:0]  off;
  logic              issuing, rd_vld, rd_first, sig_ok, scan_done;
  logic [7:0]        sig_ref;
  logic [17:0]       banks_raw;
  logic [ADDR_W-1:0] scan_addr;

  always_comb begin
    banks_raw = ({1'b0, size_acc} + 18'd4095) >> 12;
    if (banks_raw == 18'd0)     bank_last_nxt = 3'd0;
    else if (banks_raw > 18'd8) bank_last_nxt = 3'd7;
    else                        bank_last_nxt = 3'(banks_raw - 18'd1);
  end

  assign scan_addr = ADDR_W'({bnk, 12'h000}) + ADDR_W'(off);
  assign scan_done = ~issuing & rd_vld;
  assign sc_auto   = sig_ok & (size_acc >= 17'd8192);
  assign bus.rom_raddr = (state == SCAN) ? scan_addr : bus.cpu_raddr;

  // Reads go out one per cycle; the compare trails by the array's one-cycle read latency.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bnk       <= '0;
      off       <= '0;
      bank_last <= '0;
      issuing   <= 1'b0;
      rd_vld    <= 1'b0;
      rd_first  <= 1'b0;
      sig_ok    <= 1'b0;
      sig_ref   <= '0;
    end else if (state == LOAD && dl_fall) begin
      bnk       <= '0;
      off       <= '0;
      bank_last <= bank_last_nxt;
      issuing   <= 1'b1;
      rd_vld    <= 1'b0;
      sig_ok    <= 1'b1;
    end else if (state == SCAN) begin
      rd_vld   <= issuing;
      rd_first <= issuing && bnk == 3'd0 && off == '0;
      if (issuing) begin
        if (off == OFF_W'(SC_FILL_LEN - 1)) begin
          off <= '0;
          if (bnk == bank_last) issuing <= 1'b0;
          else                  bnk     <= bnk + 3'd1;
        end else begin
          off <= off + 1'b1;
        end
      end
      if (rd_vld) begin
        if (rd_first)                    sig_ref <= bus.rom_rdata;
        else if (bus.rom_rdata != sig_ref) sig_ok <= 1'b0;
      end
    end
  end
`else
  assign sc_auto       = 1'b0;
  assign bus.rom_raddr = bus.cpu_raddr;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= HOLD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (dl_rise) begin
      state_nxt = LOAD;
    end else begin
      case (state)
`ifdef ROM_SCAN_EN
        LOAD:   if (dl_fall) state_nxt = SCAN;
        SCAN:   if (scan_done) state_nxt = FINISH;
`else
        LOAD:   if (dl_fall) state_nxt = FINISH;
`endif
        FINISH: state_nxt = HOLD;
        HOLD:   if (!bus.user_reset && hold_cnt == '0) state_nxt = RUN;
        RUN:    if (bus.user_reset) state_nxt = HOLD;
        default: state_nxt = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dl_q      <= 1'b0;
      hold_cnt  <= HOLD_W'(RESET_HOLD);
      size_acc  <= '0;
      bs_dec    <= '0;
      s_tag     <= 1'b0;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      force_bs  <= '0;
      sc        <= 1'b0;
      rom_size  <= '0;
    end else begin
      dl_q   <= bus.ioctl_download;
      rom_we <= wr_ok && bus.ioctl_addr[24:ADDR_W] == '0;
      if (wr_ok) begin
        rom_waddr <= bus.ioctl_addr[ADDR_W-1:0];
        rom_wdata <= bus.ioctl_dout;
      end
      if (dl_rise) begin
        size_acc <= wr_ok ? wr_size : 17'd0;
        bs_dec   <= ext_bs;
        s_tag    <= (bus.ioctl_file_ext[7:0] == "S");
      end else if (wr_ok && wr_size > size_acc) begin
        size_acc <= wr_size;
      end
      if (state == FINISH) begin
        rom_size <= size_acc;
        force_bs <= bs_fin;
        sc       <= sc_fin;
      end
      // Reload on entry to HOLD and on every user_reset seen while holding.
      if (state_nxt == HOLD && (state != HOLD || bus.user_reset))
        hold_cnt <= HOLD_W'(RESET_HOLD);
      else if (state == HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign bus.rom_we     = rom_we;
  assign bus.rom_waddr  = rom_waddr;
  assign bus.rom_wdata  = rom_wdata;
  assign bus.force_bs   = force_bs;
  assign bus.sc         = sc;
  assign bus.rom_size   = rom_size;
  assign bus.core_reset = (state != RUN);
  assign bus.busy       = (state != RUN);
endmodule

// File: tb/tb_cart_load_ctrl.sv
// Directed bench for cart_load_ctrl with a behavioural 32 KB ROM (registered read).
// Expectations follow ROM_SCAN_EN when it is defined for the build.
module tb_cart_load_ctrl;
  localparam int RESET_HOLD  = 255;
  localparam int SC_FILL_LEN = 256;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0, n_fail = 0;
  int   we_cnt, we_bad, bsy_bad = 0;
  logic [7:0] rom [0:32767];

  always #5 clk = ~clk;

  cart_load_ctrl_if #(.ADDR_W(15)) bus ();

  cart_load_ctrl #(.ADDR_W(15), .RESET_HOLD(RESET_HOLD), .SC_FILL_LEN(SC_FILL_LEN)) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always @(posedge clk) begin
    if (bus.rom_we) rom[bus.rom_waddr] <= bus.rom_wdata;
    bus.rom_rdata <= rom[bus.rom_raddr];
  end

  function automatic logic [7:0] pat(input int a, input bit fill);
    if (fill && (a % 4096) < 256) return 8'hFF;
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
  endfunction

  function automatic int exp_lat(input int banks);
`ifdef ROM_SCAN_EN
    return RESET_HOLD + 3 + banks * SC_FILL_LEN + 1;
`else
    return RESET_HOLD + 3 + 0 * banks;
`endif
  endfunction

  function automatic int exp_scan(input int banks);
`ifdef ROM_SCAN_EN
    return banks * SC_FILL_LEN + 1;
`else
    return 0 * banks;
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_load(input logic [31:0] ext, input logic [1:0] mode);
    bus.ioctl_file_ext = ext;
    bus.sc_mode        = mode;
    bus.ioctl_download = 1'b1;
    we_cnt = 0; we_bad = 0;
    tick();
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d);
    logic exp_we;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = d;
    tick();
    exp_we = (a < 32768);
    if (bus.rom_we) we_cnt++;
    if (bus.rom_we !== exp_we ||
        (exp_we && (bus.rom_waddr !== 15'(a) || bus.rom_wdata !== d))) we_bad++;
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic write_range(input int start, input int cnt, input bit fill);
    for (int a = start; a < start + cnt; a++) wr_byte(a, pat(a, fill));
  endtask

  task automatic finish_load(input bit drop_wr, output int lat, output int scan);
    bus.ioctl_download = 1'b0; bus.ioctl_wr = drop_wr;
    bus.ioctl_addr = 25'd9000; bus.ioctl_dout = 8'hA5;
    lat = 0; scan = 0;
    while (lat < 6000) begin
      tick(); lat++;
      bus.ioctl_wr = 1'b0;
      if (bus.rom_we) we_cnt++;
      if (bus.rom_raddr !== bus.cpu_raddr) scan++;
      if (bus.busy !== bus.core_reset) bsy_bad++;
      if (bus.core_reset === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    int cnt;
    reset_n = 1'b0;
    repeat (3) tick();
    n_chk++; if (bus.core_reset !== 1'b1 || bus.busy !== 1'b1) begin n_fail++;
      $display("FAIL reset_core: core_reset=%b busy=%b want 1/1", bus.core_reset, bus.busy); end
    n_chk++; if (bus.rom_we !== 1'b0 || bus.force_bs !== 4'd0 || bus.sc !== 1'b0 || bus.rom_size !== 17'd0) begin
      n_fail++; $display("FAIL reset_outs: we=%b bs=%0d sc=%b size=%0d want 0", bus.rom_we, bus.force_bs, bus.sc, bus.rom_size); end
    reset_n = 1'b1;
    cnt = 0;
    while (bus.core_reset === 1'b1 && cnt < 1000) begin tick(); cnt++; end
    n_chk++; if (cnt !== RESET_HOLD + 1) begin n_fail++;
      $display("FAIL reset_hold: got %0d cycles want %0d", cnt, RESET_HOLD + 1); end
  endtask

  task automatic test_load_f8();
    int lat, scan;
    start_load("  F8", 2'd0);
    write_range(0, 8192, 1'b0);
    finish_load(1'b1, lat, scan);
    n_chk++; if (we_cnt !== 8192 || we_bad !== 0) begin n_fail++;
      $display("FAIL f8_writes: pulses=%0d bad=%0d want 8192/0", we_cnt, we_bad); end
    n_chk++; if (bus.force_bs !== 4'd1 || bus.rom_size !== 17'd8192 || bus.sc !== 1'b0) begin n_fail++;
      $display("FAIL f8_result: bs=%0d size=%0d sc=%b want 1/8192/0", bus.force_bs, bus.rom_size, bus.sc); end
    n_chk++; if (lat !== exp_lat(2) || scan !== exp_scan(2)) begin n_fail++;
      $display("FAIL f8_timing: lat=%0d scan=%0d want %0d/%0d", lat, scan, exp_lat(2), exp_scan(2)); end
  endtask

  task automatic test_superchip();
    int lat, scan;
    bit exp_sc;
`ifdef ROM_SCAN_EN
    exp_sc = 1'b1;
`else
    exp_sc = 1'b0;
`endif
    start_load(" BIN", 2'd0);
    write_range(0, 16384, 1'b1);
    finish_load(1'b0, lat, scan);
    n_chk++; if (we_cnt !== 16384 || we_bad !== 0) begin n_fail++;
      $display("FAIL sc_writes: pulses=%0d bad=%0d want 16384/0", we_cnt, we_bad); end
    n_chk++; if (bus.force_bs !== 4'd2 || bus.rom_size !== 17'd16384 || bus.sc !== exp_sc) begin n_fail++;
      $display("FAIL sc_result: bs=%0d size=%0d sc=%b want 2/16384/%b", bus.force_bs, bus.rom_size, bus.sc, exp_sc); end
    n_chk++; if (scan !== exp_scan(4) || lat !== exp_lat(4)) begin n_fail++;
      $display("FAIL sc_timing: scan=%0d lat=%0d want %0d/%0d", scan, lat, exp_scan(4), exp_lat(4)); end
  endtask

  task automatic test_sc_mismatch();
    int lat, scan;
    start_load(" BIN", 2'd0);
    wr_byte(16'h3080, 8'h00);
    wr_byte(16383, pat(16383, 1'b1));
    finish_load(1'b0, lat, scan);
    n_chk++; if (bus.sc !== 1'b0 || bus.force_bs !== 4'd2 || bus.rom_size !== 17'd16384) begin n_fail++;
      $display("FAIL mismatch_sc: sc=%b bs=%0d size=%0d want 0/2/16384", bus.sc, bus.force_bs, bus.rom_size); end
    start_load(".F6S", 2'd0);
    wr_byte(16383, pat(16383, 1'b1));
    finish_load(1'b0, lat, scan);
    n_chk++; if (bus.sc !== 1'b1 || bus.force_bs !== 4'd2) begin n_fail++;
      $display("FAIL s_tag: sc=%b bs=%0d want 1/2", bus.sc, bus.force_bs); end
    start_load(".F6S", 2'd1);
    wr_byte(16383, pat(16383, 1'b1));
    finish_load(1'b0, lat, scan);
    n_chk++; if (bus.sc !== 1'b0) begin n_fail++;
      $display("FAIL sc_force_off: sc=%b want 0", bus.sc); end
  endtask

  task automatic test_empty();
    int lat, scan;
    start_load(" BIN", 2'd0);
    finish_load(1'b0, lat, scan);
    n_chk++; if (bus.rom_size !== 17'd0 || bus.force_bs !== 4'd0 || bus.sc !== 1'b0 || we_cnt !== 0) begin n_fail++;
      $display("FAIL empty: size=%0d bs=%0d sc=%b we=%0d want 0/0/0/0", bus.rom_size, bus.force_bs, bus.sc, we_cnt); end
    n_chk++; if (lat !== exp_lat(1) || scan !== exp_scan(1)) begin n_fail++;
      $display("FAIL empty_timing: lat=%0d scan=%0d want %0d/%0d", lat, scan, exp_lat(1), exp_scan(1)); end
  endtask

  task automatic test_abort();
    int lat, scan, cr_bad;
    bit in_scan, exp_in_scan;
`ifdef ROM_SCAN_EN
    exp_in_scan = 1'b1;
`else
    exp_in_scan = 1'b0;
`endif
    cr_bad = 0;
    start_load(" BIN", 2'd0);
    wr_byte(16383, 8'h11);
    bus.ioctl_download = 1'b0;
    repeat (100) begin tick(); if (bus.core_reset !== 1'b1) cr_bad++; end
    in_scan = (bus.rom_raddr !== bus.cpu_raddr);
    n_chk++; if (in_scan !== exp_in_scan) begin n_fail++;
      $display("FAIL abort_midscan: scanning=%b want %b", in_scan, exp_in_scan); end
    start_load("x.3F", 2'd0);
    if (bus.core_reset !== 1'b1) cr_bad++;
    n_chk++; if (bus.rom_raddr !== bus.cpu_raddr) begin n_fail++;
      $display("FAIL abort_raddr: raddr=%h want %h", bus.rom_raddr, bus.cpu_raddr); end
    wr_byte(99, 8'h22);
    if (bus.core_reset !== 1'b1) cr_bad++;
    finish_load(1'b0, lat, scan);
    n_chk++; if (bus.rom_size !== 17'd100 || bus.force_bs !== 4'd5 || cr_bad !== 0) begin n_fail++;
      $display("FAIL abort_result: size=%0d bs=%0d cr_drops=%0d want 100/5/0", bus.rom_size, bus.force_bs, cr_bad); end
    n_chk++; if (lat !== exp_lat(1)) begin n_fail++;
      $display("FAIL abort_timing: lat=%0d want %0d", lat, exp_lat(1)); end
  endtask

  task automatic test_big();
    int lat, scan;
    start_load(" BIN", 2'd2);
    write_range(32760, 16, 1'b0);
    wr_byte(39999, 8'h33);
    finish_load(1'b0, lat, scan);
    n_chk++; if (we_cnt !== 8 || we_bad !== 0) begin n_fail++;
      $display("FAIL big_writes: pulses=%0d bad=%0d want 8/0", we_cnt, we_bad); end
    n_chk++; if (bus.rom_size !== 17'd40000 || bus.force_bs !== 4'd0 || bus.sc !== 1'b1) begin n_fail++;
      $display("FAIL big_result: size=%0d bs=%0d sc=%b want 40000/0/1", bus.rom_size, bus.force_bs, bus.sc); end
    n_chk++; if (lat !== exp_lat(8)) begin n_fail++;
      $display("FAIL big_timing: lat=%0d want %0d", lat, exp_lat(8)); end
  endtask

  task automatic test_user_reset();
    int hi;
    bus.user_reset = 1'b1;
    tick();
    bus.user_reset = 1'b0;
    hi = 0;
    while (bus.core_reset === 1'b1 && hi < 1000) begin hi++; tick(); end
    n_chk++; if (hi !== RESET_HOLD + 1) begin n_fail++;
      $display("FAIL user_reset_hold: got %0d cycles want %0d", hi, RESET_HOLD + 1); end
    n_chk++; if (bus.rom_size !== 17'd40000 || bus.force_bs !== 4'd0 || bus.sc !== 1'b1) begin n_fail++;
      $display("FAIL user_reset_keep: size=%0d bs=%0d sc=%b want 40000/0/1", bus.rom_size, bus.force_bs, bus.sc); end
  endtask

  task automatic test_reset_mid_load();
    int cnt;
    start_load("  F8", 2'd0);
    write_range(0, 4, 1'b0);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd5; bus.ioctl_dout = 8'h44;
    reset_n = 1'b0; bus.ioctl_download = 1'b0;
    tick();
    bus.ioctl_wr = 1'b0;
    n_chk++; if (bus.rom_we !== 1'b0 || bus.force_bs !== 4'd0 || bus.sc !== 1'b0 ||
                 bus.rom_size !== 17'd0 || bus.core_reset !== 1'b1) begin n_fail++;
      $display("FAIL midload_reset: we=%b bs=%0d sc=%b size=%0d cr=%b want 0/0/0/0/1",
               bus.rom_we, bus.force_bs, bus.sc, bus.rom_size, bus.core_reset); end
    reset_n = 1'b1;
    cnt = 0;
    while (bus.core_reset === 1'b1 && cnt < 1000) begin tick(); cnt++; end
    n_chk++; if (cnt !== RESET_HOLD + 1 || bus.rom_size !== 17'd0) begin n_fail++;
      $display("FAIL midload_release: cycles=%0d size=%0d want %0d/0", cnt, bus.rom_size, RESET_HOLD + 1); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rom[i] = 8'h00;
    reset_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_file_ext = "    ";
    bus.sc_mode        = 2'd0;
    bus.user_reset     = 1'b0;
    bus.cpu_raddr      = 15'h7ABC;
    test_reset();
    test_load_f8();
    test_superchip();
    test_sc_mismatch();
    test_empty();
    test_abort();
    test_big();
    test_user_reset();
    test_reset_mid_load();
    n_chk++; if (bsy_bad !== 0) begin n_fail++;
      $display("FAIL busy_track: %0d samples with busy != core_reset, want 0", bsy_bad); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
